// File: rtl/credit_bp_tx_if.sv
// Link bundle between the credit transmitter and the receiver's VC FIFOs:
// registered packet plus one-hot VC target going out, per-VC credit grants coming back.
interface noc_if #(
    parameter int VC_W = 2,
    parameter int D_W  = 8,
    parameter int A_W  = 4
);
    typedef struct packed {
        logic [A_W-1:0] addr;
    } route_t;

    typedef struct packed {
        logic           last;
        logic [D_W-1:0] data;
    } payload_t;

    typedef struct packed {
        route_t   routeinfo;
        payload_t payload;
    } packet_t;

    logic [VC_W-1:0] credit_vc_target;
    packet_t         credit_packet;
    logic [VC_W-1:0] credit_vc_credit_gnt;

    modport transmitter (
        output credit_vc_target,
        output credit_packet,
        input  credit_vc_credit_gnt
    );

    modport receiver (
        input  credit_vc_target,
        input  credit_packet,
        output credit_vc_credit_gnt
    );

    modport master (
        output credit_vc_target,
        output credit_packet,
        input  credit_vc_credit_gnt
    );

    modport slave (
        input  credit_vc_target,
        input  credit_packet,
        output credit_vc_credit_gnt
    );
endinterface

// File: rtl/credit_bp_tx.sv
// Credit-based transmitter: per-VC credit counters, round-robin pick among VCs
// holding both data and credit, one registered packet per cycle onto the link.
module credit_bp_tx #(
    parameter int VC_W  = 2,
    parameter int D_W   = 8,
    parameter int A_W   = 4,
    parameter int DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VC_W-1:0]               i_v,
    input  logic [VC_W-1:0][A_W+D_W:0]    i_d,
    output logic [VC_W-1:0]               o_b,
    noc_if.transmitter                    to_rx
);
    localparam int CNT_W = $clog2(DEPTH);
    localparam int IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam logic [CNT_W-1:0] MAX_CREDIT = CNT_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_VC    = IDX_W'(VC_W - 1);

    logic [CNT_W-1:0] credit [VC_W];
    logic [IDX_W-1:0] last_winner;
    logic [VC_W-1:0]  eligible;
    logic [VC_W-1:0]  send_vec;
    logic [VC_W-1:0]  overflow;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;

    logic [VC_W-1:0]  tgt_q;
    logic             pkt_last;
    logic [A_W-1:0]   pkt_addr;
    logic [D_W-1:0]   pkt_data;

    // Eligibility looks only at registered credit, so a grant is usable next cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < VC_W; i++) begin
            eligible[i] = i_v[i] && (credit[i] != '0);
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= VC_W; k++) begin
            cand = IDX_W'((int'(last_winner) + k) % VC_W);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        send_vec = '0;
        overflow = '0;
        for (int i = 0; i < VC_W; i++) begin
            send_vec[i] = rst && found && (winner == IDX_W'(i));
            overflow[i] = to_rx.credit_vc_credit_gnt[i] && !send_vec[i] && (credit[i] == MAX_CREDIT);
        end
    end

    assign o_b = ~send_vec;

    // A send and a grant on the same VC cancel; an unmatched grant at full credit saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < VC_W; i++) begin
                credit[i] <= MAX_CREDIT;
            end
            last_winner <= LAST_VC;
            tgt_q       <= '0;
            pkt_last    <= 1'b0;
            pkt_addr    <= '0;
            pkt_data    <= '0;
        end else begin
            for (int i = 0; i < VC_W; i++) begin
                case ({send_vec[i], to_rx.credit_vc_credit_gnt[i]})
                    2'b10:   credit[i] <= credit[i] - 1'b1;
                    2'b01:   if (credit[i] != MAX_CREDIT) credit[i] <= credit[i] + 1'b1;
                    default: credit[i] <= credit[i];
                endcase
            end
            tgt_q <= send_vec;
            if (found) begin
                last_winner <= winner;
                pkt_last    <= i_d[winner][A_W+D_W];
                pkt_addr    <= i_d[winner][A_W+D_W-1:D_W];
                pkt_data    <= i_d[winner][D_W-1:0];
            end
        end
    end

    assign to_rx.credit_vc_target              = tgt_q;
    assign to_rx.credit_packet.routeinfo.addr  = pkt_addr;
    assign to_rx.credit_packet.payload.last    = pkt_last;
    assign to_rx.credit_packet.payload.data    = pkt_data;

    logic [VC_W-1:0] send_at_zero;
    always_comb begin
        send_at_zero = '0;
        for (int i = 0; i < VC_W; i++) begin
            send_at_zero[i] = send_vec[i] && (credit[i] == '0);
        end
    end

    a_depth_multiple: assert property (@(posedge clk) (DEPTH % 32) == 0)
        else $error("credit_bp_tx: DEPTH must be a multiple of 32");

    a_target_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(to_rx.credit_vc_target))
        else $error("credit_bp_tx: credit_vc_target not onehot0");

    a_no_send_zero: assert property (@(posedge clk) disable iff (!rst)
        send_at_zero == '0)
        else $error("credit_bp_tx: send with zero credit");

    a_known: assert property (@(posedge clk) disable iff (!rst)
        !$isunknown({o_b, to_rx.credit_vc_target, to_rx.credit_vc_credit_gnt}))
        else $error("credit_bp_tx: unknown on link or backpressure");

    a_accept_is_send: assert property (@(posedge clk) disable iff (!rst)
        (i_v & ~o_b) == send_vec)
        else $error("credit_bp_tx: o_b low with valid did not transfer");

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        overflow == '0)
        else $error("credit_bp_tx: credit grant overflow");

endmodule

// File: tb/tb_credit_bp_tx.sv
// Randomised and directed bench for credit_bp_tx against a queue-free
// arithmetic model of credits and round-robin priority.
module tb_credit_bp_tx;
    localparam int VC_W  = 2;
    localparam int D_W   = 8;
    localparam int A_W   = 4;
    localparam int DEPTH = 32;
    localparam int MAXC  = DEPTH - 1;
    localparam int W     = A_W + D_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [VC_W-1:0]        i_v = '0;
    logic [VC_W-1:0][W-1:0] i_d = '0;
    logic [VC_W-1:0]        o_b;

    noc_if #(.VC_W(VC_W), .D_W(D_W), .A_W(A_W)) link();

    credit_bp_tx #(.VC_W(VC_W), .D_W(D_W), .A_W(A_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_v   (i_v),
        .i_d   (i_d),
        .o_b   (o_b),
        .to_rx (link)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int              mcred [VC_W];
    int              mlw;
    int              exp_win;
    logic [VC_W-1:0] exp_ob;
    logic [VC_W-1:0] exp_tgt;
    logic [W-1:0]    exp_word;

    initial link.credit_vc_credit_gnt = '0;

    // Applies one cycle of inputs at the falling edge and predicts backpressure.
    task automatic drive(input logic r, input logic [VC_W-1:0] v,
                         input logic [VC_W-1:0][W-1:0] d, input logic [VC_W-1:0] g);
        @(negedge clk);
        rst = r;
        i_v = v;
        i_d = d;
        link.credit_vc_credit_gnt = g;
        #1;
        exp_win = -1;
        exp_ob  = '1;
        if (r) begin
            for (int k = 1; k <= VC_W; k++) begin
                if (exp_win < 0 && v[(mlw + k) % VC_W] && mcred[(mlw + k) % VC_W] > 0)
                    exp_win = (mlw + k) % VC_W;
            end
        end
        if (exp_win >= 0) exp_ob[exp_win] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < VC_W; i++) mcred[i] = MAXC;
            mlw     = VC_W - 1;
            exp_tgt = '0;
        end else begin
            exp_tgt = '0;
            if (exp_win >= 0) begin
                mcred[exp_win]--;
                mlw = exp_win;
                exp_tgt[exp_win] = 1'b1;
                exp_word = i_d[exp_win];
            end
            for (int i = 0; i < VC_W; i++) begin
                if (link.credit_vc_credit_gnt[i] && mcred[i] < MAXC) mcred[i]++;
            end
        end
    endtask

    function automatic logic [VC_W-1:0][W-1:0] rand_d();
        logic [VC_W-1:0][W-1:0] d;
        for (int i = 0; i < VC_W; i++) d[i] = W'($urandom);
        return d;
    endfunction

    task automatic do_reset();
        drive(1'b0, '0, '0, '0);
        tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 2'b11, rand_d(), '0);
            checks++;
            if (o_b !== 2'b11) begin failures++; $display("FAIL reset_ob: got %b want 11", o_b); end
            checks++;
            if (link.credit_vc_target !== 2'b00) begin failures++; $display("FAIL reset_tgt: got %b want 00", link.credit_vc_target); end
            tick();
        end
        drive(1'b1, 2'b11, rand_d(), '0);
        checks++;
        if (o_b !== 2'b10 || o_b !== exp_ob) begin failures++; $display("FAIL first_winner_ob: got %b want 10", o_b); end
        tick();
        drive(1'b1, 2'b00, rand_d(), '0);
        checks++;
        if (link.credit_vc_target !== 2'b01) begin failures++; $display("FAIL first_winner_tgt: got %b want 01", link.credit_vc_target); end
        checks++;
        if (dut.credit[0] !== 5'd30) begin failures++; $display("FAIL first_credit: got %0d want 30", dut.credit[0]); end
        tick();
    endtask

    task automatic test_credit_exhaust();
        int sent;
        sent = 0;
        do_reset();
        for (int c = 0; c < 34; c++) begin
            drive(1'b1, 2'b01, rand_d(), '0);
            checks++;
            if (o_b !== exp_ob) begin failures++; $display("FAIL exhaust_ob c=%0d: got %b want %b", c, o_b, exp_ob); end
            checks++;
            if (link.credit_vc_target !== exp_tgt) begin failures++; $display("FAIL exhaust_tgt c=%0d: got %b want %b", c, link.credit_vc_target, exp_tgt); end
            if (c >= 31) begin
                checks++;
                if (o_b[0] !== 1'b1) begin failures++; $display("FAIL exhaust_stall c=%0d: got o_b[0]=%b want 1", c, o_b[0]); end
            end
            if (link.credit_vc_target == 2'b01) sent++;
            tick();
        end
        checks++;
        if (sent != 31) begin failures++; $display("FAIL exhaust_count: got %0d want 31", sent); end
        drive(1'b1, 2'b01, rand_d(), 2'b01);
        checks++;
        if (o_b[0] !== 1'b1) begin failures++; $display("FAIL grant_same_cycle: got o_b[0]=%b want 1", o_b[0]); end
        tick();
        drive(1'b1, 2'b01, rand_d(), '0);
        checks++;
        if (o_b[0] !== 1'b0) begin failures++; $display("FAIL grant_next_cycle: got o_b[0]=%b want 0", o_b[0]); end
        tick();
        drive(1'b1, 2'b00, rand_d(), '0);
        checks++;
        if (link.credit_vc_target !== 2'b01) begin failures++; $display("FAIL grant_send_tgt: got %b want 01", link.credit_vc_target); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] rr_tab [4];
        rr_tab = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 2'b11, rand_d(), '0);
            checks++;
            if (o_b !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_ob c=%0d: got %b", c, o_b); end
            if (c >= 1) begin
                checks++;
                if (link.credit_vc_target !== rr_tab[c-1]) begin failures++; $display("FAIL rr_tgt c=%0d: got %b want %b", c, link.credit_vc_target, rr_tab[c-1]); end
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 0; c < 30; c++) begin
            drive(1'b1, 2'b10, rand_d(), '0);
            tick();
        end
        drive(1'b1, 2'b10, rand_d(), 2'b10);
        checks++;
        if (dut.credit[1] !== 5'd1) begin failures++; $display("FAIL sim_setup: got %0d want 1", dut.credit[1]); end
        checks++;
        if (o_b !== 2'b01) begin failures++; $display("FAIL sim_send: got %b want 01", o_b); end
        tick();
        drive(1'b1, 2'b10, rand_d(), '0);
        checks++;
        if (dut.credit[1] !== 5'd1) begin failures++; $display("FAIL sim_hold: got %0d want 1", dut.credit[1]); end
        checks++;
        if (o_b !== 2'b01) begin failures++; $display("FAIL sim_still_eligible: got %b want 01", o_b); end
        tick();
        drive(1'b1, 2'b10, rand_d(), '0);
        checks++;
        if (dut.credit[1] !== 5'd0) begin failures++; $display("FAIL sim_drain: got %0d want 0", dut.credit[1]); end
        checks++;
        if (o_b !== 2'b11) begin failures++; $display("FAIL sim_blocked: got %b want 11", o_b); end
        tick();
    endtask

    task automatic test_payload();
        logic [VC_W-1:0][W-1:0] d;
        do_reset();
        d    = rand_d();
        d[0] = {1'b1, 4'd5, 8'hA5};
        drive(1'b1, 2'b01, d, '0);
        tick();
        drive(1'b1, 2'b00, rand_d(), '0);
        checks++;
        if (link.credit_packet.payload.last !== 1'b1) begin failures++; $display("FAIL pay_last: got %b want 1", link.credit_packet.payload.last); end
        checks++;
        if (link.credit_packet.routeinfo.addr !== 4'd5) begin failures++; $display("FAIL pay_addr: got %0d want 5", link.credit_packet.routeinfo.addr); end
        checks++;
        if (link.credit_packet.payload.data !== 8'hA5) begin failures++; $display("FAIL pay_data: got %h want a5", link.credit_packet.payload.data); end
        checks++;
        if (link.credit_vc_target !== 2'b01) begin failures++; $display("FAIL pay_tgt: got %b want 01", link.credit_vc_target); end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 21; c++) begin
            drive(1'b1, 2'b01, rand_d(), '0);
            tick();
        end
        drive(1'b0, 2'b11, rand_d(), '0);
        checks++;
        if (dut.credit[0] !== 5'd10 || link.credit_vc_target !== 2'b01) begin
            failures++; $display("FAIL mid_setup: got credit=%0d tgt=%b want 10/01", dut.credit[0], link.credit_vc_target);
        end
        checks++;
        if (o_b !== 2'b11) begin failures++; $display("FAIL mid_reset_ob: got %b want 11", o_b); end
        tick();
        drive(1'b1, 2'b11, rand_d(), '0);
        checks++;
        if (link.credit_vc_target !== 2'b00) begin failures++; $display("FAIL mid_flush: got %b want 00", link.credit_vc_target); end
        checks++;
        if (dut.credit[0] !== 5'd31) begin failures++; $display("FAIL mid_credit: got %0d want 31", dut.credit[0]); end
        checks++;
        if (o_b !== 2'b10) begin failures++; $display("FAIL mid_restart: got %b want 10", o_b); end
        tick();
    endtask

    task automatic test_random();
        logic [VC_W-1:0] v, g;
        logic            r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = VC_W'($urandom);
            r = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < VC_W; i++)
                g[i] = ($urandom_range(0, 3) == 0) && (mcred[i] < MAXC);
            drive(r, v, rand_d(), g);
            checks++;
            if (o_b !== exp_ob) begin failures++; $display("FAIL rnd_ob c=%0d: got %b want %b", c, o_b, exp_ob); end
            checks++;
            if (link.credit_vc_target !== exp_tgt) begin failures++; $display("FAIL rnd_tgt c=%0d: got %b want %b", c, link.credit_vc_target, exp_tgt); end
            if (exp_tgt != '0) begin
                checks++;
                if ({link.credit_packet.payload.last, link.credit_packet.routeinfo.addr, link.credit_packet.payload.data} !== exp_word) begin
                    failures++;
                    $display("FAIL rnd_pkt c=%0d: got %h want %h", c,
                             {link.credit_packet.payload.last, link.credit_packet.routeinfo.addr, link.credit_packet.payload.data}, exp_word);
                end
            end
            for (int i = 0; i < VC_W; i++) begin
                checks++;
                if (dut.credit[i] !== 5'(mcred[i])) begin failures++; $display("FAIL rnd_credit c=%0d vc=%0d: got %0d want %0d", c, i, dut.credit[i], mcred[i]); end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < VC_W; i++) mcred[i] = MAXC;
        mlw      = VC_W - 1;
        exp_win  = -1;
        exp_ob   = '1;
        exp_tgt  = '0;
        exp_word = '0;
        test_reset();
        test_credit_exhaust();
        test_round_robin();
        test_simultaneous();
        test_payload();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/credit_bp_tx.md
Name: credit_bp_tx

Overview:
Transmitter half of the credit-based backpressure link. It accepts per-VC packets from the t/pi switch output over a DVR interface and keeps one credit counter per VC that mirrors free slots in the receiver's VC FIFO. Each cycle it arbitrates round-robin among VCs that have both data and credit, then drives at most one registered packet per cycle onto the noc_if link. Credits come back through the per-VC grant lines.

Parameters:
VC_W, DEFAULT_VC_W, number of virtual channels.
D_W, DEFAULT_D_W, payload data width.
A_W, DEFAULT_A_W, route address width.
DEPTH, DEFAULT_VC_FIFO_DEPTH, receiver FIFO depth parameter. Must be a multiple of 32. Usable credits per VC are DEPTH-1.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-low reset; logic is in reset while rst==0.
i_v  input  [VC_W-1:0]  per-VC valid from the switch.
i_d  input  [VC_W-1:0][A_W+D_W:0]  per-VC word, packed {last, addr, data}.
o_b  output  [VC_W-1:0]  per-VC backpressure; a word transfers when i_v[ii] & !o_b[ii].
to_rx  noc_if.transmitter  —  drives credit_vc_target[VC_W-1:0] (one-hot or zero), credit_packet (routeinfo.addr, payload.data, payload.last); samples credit_vc_credit_gnt[VC_W-1:0].

Behaviour:
- Credit counters: one per VC, width $clog2(DEPTH), reset value DEPTH-1.
- Per cycle, per VC: decrement on send, increment when credit_vc_credit_gnt[ii] is asserted, unchanged when both happen together.
- Eligibility uses only the registered counter value. A grant makes a credit usable on the next cycle, not the same cycle.
- Eligible VC: i_v[ii] && credit[ii]!=0.
- Arbiter: round-robin. The search starts at last_winner+1 and wraps modulo VC_W. last_winner resets to VC_W-1, so VC0 has first priority after reset. last_winner updates only when a send happens.
- o_b: combinational. o_b[ii]=0 only for the winning VC; all others are 1. When no VC is eligible, all bits are 1. During reset (rst==0), all bits are 1. o_b[ii] is never 0 while credit[ii]==0.
- Output register, 1-cycle latency. A word accepted in cycle N appears in cycle N+1 as:
  - credit_vc_target = one-hot(winner)
  - credit_packet.payload.last = i_d[w][A_W+D_W]
  - routeinfo.addr = i_d[w][A_W+D_W-1:D_W]
  - payload.data = i_d[w][D_W-1:0]
- With no accept in cycle N, credit_vc_target is 0 in N+1. credit_packet contents are don't-care in that case, but the register holds its previous value so nothing is X after the first send.
- At most one bit of credit_vc_target is set in any cycle. Full throughput is one word per cycle across all VCs.
- Reset state: counters=DEPTH-1, credit_vc_target=0, last_winner=VC_W-1. Reset mid-operation discards any in-flight registered packet (target forced 0 on the next edge) and restores all credits. The receiver must be reset together with this block.
- Counter overflow: a grant when credit==DEPTH-1 with no simultaneous send is a protocol error. The counter saturates at DEPTH-1 and a SIMULATION assertion fires.
- SIMULATION assertions:
  - credit_vc_target is onehot0.
  - No send with credit==0.
  - o_b, credit_vc_target and credit_vc_credit_gnt are not unknown out of reset.
  - An o_b bit that drops to 0 while i_v is high results in a transfer that cycle.

Test Plan:
1. VC_W=2, DEPTH=32. Hold rst=0 for 3 cycles with i_v=2'b11 → o_b=2'b11, credit_vc_target=0. Release reset → first send is VC0 and counter[0] goes 31→30.
2. Stream VC0 only, no grants → exactly 31 words are sent on consecutive cycles. o_b[0]=1 from the 32nd cycle on. Pulse gnt[0] for one cycle → one more word is accepted on the following cycle and credit_vc_target=2'b01 one cycle after that.
3. Both VCs valid continuously with ample credits → credit_vc_target sequence 01,10,01,10. Each o_b bit is low on alternate cycles.
4. counter[1]=1 with a send from VC1 and gnt[1] in the same cycle → counter stays 1 and VC1 stays eligible next cycle. Same setup with no gnt → counter 0 and o_b[1]=1.
5. i_d[0]={1'b1, addr=5, data=0xA5} accepted → next cycle payload.last=1, routeinfo.addr=5, payload.data=0xA5, credit_vc_target=2'b01.
6. Assert rst=0 while counter[0]=10 and a packet is in flight → next cycle credit_vc_target=0 and counter[0]=31. After release, arbitration restarts at VC0.
